alu_pipe: RTL
=============

# alu_pipe

Parametrised, two-stage pipelined ALU with valid/ready handshakes, eight operations, a full flag set and an accumulator mode. It is the registered successor of the combinational add/sub/AND/OR datapath. It sits between an operand source and a result consumer, and both sides may stall.

## Interface

Parameters:
- NB_size, 16: operand and result width in bits; minimum 4.
- NB_shamt, $clog2(NB_size): shift-amount width, derived; not overridden.

Ports:
- i_clk  in  1  single clock; all state is rising-edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  an input operation is presented.
- o_ready  out  1  the block accepts the input this cycle.
- i_sel  in  3  opcode.
- i_acc_mode  in  1  when 1, operand A is the internal accumulator and the result updates the accumulator.
- i_dataA  in  NB_size  signed operand A; ignored when i_acc_mode=1.
- i_dataB  in  NB_size  signed operand B.
- o_valid  out  1  a result is presented.
- i_ready  in  1  the consumer accepts the result.
- o_dataC  out  NB_size  signed result.
- o_carry  out  1  add carry-out, or subtract borrow.
- o_ovf  out  1  signed overflow.
- o_zero  out  1  o_dataC == 0.
- o_neg  out  1  o_dataC[NB_size-1].

## Operation

Opcodes:
- 000 ADD: A+B. Carry = bit NB_size of the unsigned sum. Ovf = the operand signs are equal and the result sign differs.
- 001 SUB: A-B. Carry = borrow (unsigned A < unsigned B). Ovf = the operand signs differ and the result sign differs from A.
- 010 AND, 011 OR, 100 XOR: bitwise. Carry=0, ovf=0.
- 101 SLT: result 1 if signed A < signed B, else 0. Carry=0, ovf=0.
- 110 SLL: A << B[NB_shamt-1:0]. Carry=0, ovf=0.
- 111 SRA: A >>> B[NB_shamt-1:0], sign-filling. Carry=0, ovf=0.

Accumulator:
- acc is an internal NB_size register; it resets to 0.
- In an acc-mode op, operand A is the value of acc at the moment the op's result is computed, i.e. when it moves from stage 1 to stage 2.
- acc is loaded with the result on that same advance, and only for acc-mode ops. Non-acc ops never modify acc.
- Back-to-back acc-mode ops therefore chain with no bubble: op N sees the result of op N-1.

Handshake:
- Transfer in: i_valid && o_ready. Transfer out: o_valid && i_ready.
- Pipeline enable: en = !o_valid || i_ready.
- o_ready = en || !s1_valid, so stage 1 may fill while stage 2 is stalled.
- While o_valid=1 and i_ready=0, o_dataC and all flags hold stable.
- Order is preserved. No result is dropped or duplicated.

## Timing

- Latency is 2 cycles, measured from the input transfer edge to the first edge with o_valid=1.
- Throughput is 1 op per cycle while i_ready=1.
- Stage 1 registers i_sel, i_acc_mode, A and B, plus s1_valid.
- On the stage-1 to stage-2 advance, the combinational core computes the result and flags; stage 2 registers them together with o_valid and the acc update.
- Stalls:
  - If stage 2 is stalled and stage 1 is empty, stage 1 captures one new input.
  - If stage 2 is stalled and stage 1 is full, o_ready=0.
- Simultaneous output accept and input transfer in the same cycle: both occur, and occupancy is unchanged.
- Reset (asynchronous, takes effect immediately):
  - s1_valid, o_valid, acc, o_dataC and all flags go to 0.
  - o_ready reads 1 after reset.
  - In-flight ops are discarded.
  - Deasserting reset mid-stream yields no stale output.

## Structure

- Shared package alu_pkg holds the opcode localparams (ALU_ADD … ALU_SRA) and the opcode width 3.
- Sub-module alu_core: purely combinational, takes (op, A, B) and produces (result, carry, ovf). It is instantiated once between the stages.
- zero and neg are derived from the core result before the stage-2 register.

## Test plan

1. ADD, A=0x7FFF, B=0x0001, i_ready=1 -> after 2 cycles o_dataC=0x8000, ovf=1, carry=0, neg=1, zero=0.
2. SUB, A=0x0003, B=0x0005 -> o_dataC=0xFFFE, carry=1, ovf=0, neg=1. SUB 0x1234-0x1234 -> 0x0000, zero=1, carry=0.
3. SRA 0x8000 by B=4 -> 0xF800. SLL 0x0001 by 15 -> 0x8000. SLT A=0xFFFF, B=0x0001 -> 0x0001.
4. Accumulator: after reset, three back-to-back acc-mode ADDs with B=5 -> results 5, 10, 15. Then a non-acc ADD 1+1 -> 2, then an acc-mode ADD with B=1 -> 16.
5. Backpressure: stream ADDs with A=1..6, B=0, and hold i_ready=0 for cycles 3–6.
   - o_ready drops once both stages are full.
   - o_dataC holds its value while stalled.
   - The output sequence is exactly 1..6 with no gaps or repeats.
6. Reset: assert i_rst with two ops in flight and acc=15.
   - o_valid=0 immediately.
   - After release, an acc-mode ADD with B=3 -> 3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU.
// Opcode encodings and small inter-stage bundles.
package alu_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t ALU_ADD = 3'b000;
  localparam op_t ALU_SUB = 3'b001;
  localparam op_t ALU_AND = 3'b010;
  localparam op_t ALU_OR  = 3'b011;
  localparam op_t ALU_XOR = 3'b100;
  localparam op_t ALU_SLT = 3'b101;
  localparam op_t ALU_SLL = 3'b110;
  localparam op_t ALU_SRA = 3'b111;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath between the two pipeline stages.
// Produces the result plus carry/borrow and signed overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int NB_size  = 16,
  parameter int NB_shamt = $clog2(NB_size)
) (
  input  op_t                i_op,
  input  logic [NB_size-1:0] i_a,
  input  logic [NB_size-1:0] i_b,
  output logic [NB_size-1:0] o_res,
  output logic               o_carry,
  output logic               o_ovf
);

  localparam int MSB = NB_size - 1;

  logic [NB_size:0]    sum;
  logic [NB_size:0]    diff;
  logic [NB_shamt-1:0] shamt;
  logic                lt;

  // Shared adder/subtractor terms, extended by one bit for carry/borrow
  always_comb begin
    sum   = {1'b0, i_a} + {1'b0, i_b};
    diff  = {1'b0, i_a} - {1'b0, i_b};
    shamt = i_b[NB_shamt-1:0];
    lt    = $signed(i_a) < $signed(i_b);
  end

  // Opcode select; only ADD/SUB report carry and overflow
  always_comb begin
    o_res   = '0;
    o_carry = 1'b0;
    o_ovf   = 1'b0;
    unique case (i_op)
      ALU_ADD: begin
        o_res   = sum[MSB:0];
        o_carry = sum[NB_size];
        o_ovf   = (i_a[MSB] == i_b[MSB])
                && (sum[MSB] != i_a[MSB]);
      end
      ALU_SUB: begin
        o_res   = diff[MSB:0];
        o_carry = diff[NB_size];
        o_ovf   = (i_a[MSB] != i_b[MSB])
                && (diff[MSB] != i_a[MSB]);
      end
      ALU_AND: o_res = i_a & i_b;
      ALU_OR:  o_res = i_a | i_b;
      ALU_XOR: o_res = i_a ^ i_b;
      ALU_SLT: o_res = {{(NB_size-1){1'b0}}, lt};
      ALU_SLL: o_res = i_a << shamt;
      ALU_SRA: o_res = NB_size'($signed(i_a) >>> shamt);
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides.
// Stage 1 holds operands; stage 2 holds result, flags and acc.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int NB_size  = 16,
  parameter int NB_shamt = $clog2(NB_size)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [OP_W-1:0]    i_sel,
  input  logic               i_acc_mode,
  input  logic [NB_size-1:0] i_dataA,
  input  logic [NB_size-1:0] i_dataB,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_size-1:0] o_dataC,
  output logic               o_carry,
  output logic               o_ovf,
  output logic               o_zero,
  output logic               o_neg
);

  logic en;
  logic in_fire;

  logic               s1_valid_q, s1_valid_d;
  op_t                s1_sel_q,   s1_sel_d;
  logic               s1_acc_q,   s1_acc_d;
  logic [NB_size-1:0] s1_a_q,     s1_a_d;
  logic [NB_size-1:0] s1_b_q,     s1_b_d;

  logic               o_valid_q,  o_valid_d;
  logic [NB_size-1:0] data_q,     data_d;
  flags_t             flg_q,      flg_d;
  logic [NB_size-1:0] acc_q,      acc_d;

  logic [NB_size-1:0] core_a;
  logic [NB_size-1:0] core_res;
  logic               core_carry;
  logic               core_ovf;

  // Stage 2 advances when empty or drained; stage 1 may
  // still fill behind a stalled stage 2
  always_comb begin
    en      = !o_valid_q || i_ready;
    o_ready = en || !s1_valid_q;
    in_fire = i_valid && o_ready;
    core_a  = s1_acc_q ? acc_q : s1_a_q;
  end

  alu_core #(
    .NB_size  (NB_size),
    .NB_shamt (NB_shamt)
  ) u_core (
    .i_op    (s1_sel_q),
    .i_a     (core_a),
    .i_b     (s1_b_q),
    .o_res   (core_res),
    .o_carry (core_carry),
    .o_ovf   (core_ovf)
  );

  // Stage 1 next state: load on accept, empty when it advances
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sel_d   = s1_sel_q;
    s1_acc_d   = s1_acc_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_sel_d   = i_sel;
      s1_acc_d   = i_acc_mode;
      s1_a_d     = i_dataA;
      s1_b_d     = i_dataB;
    end else if (en) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state: capture result/flags and acc on advance
  always_comb begin
    o_valid_d = o_valid_q;
    data_d    = data_q;
    flg_d     = flg_q;
    acc_d     = acc_q;
    if (en) begin
      o_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        data_d    = core_res;
        flg_d     = '{carry: core_carry,
                      ovf:   core_ovf,
                      zero:  (core_res == '0),
                      neg:   core_res[NB_size-1]};
        if (s1_acc_q) begin
          acc_d = core_res;
        end
      end
    end
  end

  // Stage 1 operand register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_sel_q   <= ALU_ADD;
      s1_acc_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sel_q   <= s1_sel_d;
      s1_acc_q   <= s1_acc_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
    end
  end

  // Stage 2 result register and accumulator
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid_q <= 1'b0;
      data_q    <= '0;
      flg_q     <= '0;
      acc_q     <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      data_q    <= data_d;
      flg_q     <= flg_d;
      acc_q     <= acc_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_dataC = data_q;
  assign o_carry = flg_q.carry;
  assign o_ovf   = flg_q.ovf;
  assign o_zero  = flg_q.zero;
  assign o_neg   = flg_q.neg;

endmodule
